// File: rtl/lcd_pkg.sv
// Shared ILI9488 definitions: script entry kinds, panel opcodes and the
// sequencer state encoding. The colour-fill stage imports the same package.
// Build option LCD_INIT_GAMMA_EN changes the script depth.
package lcd_pkg;

  // Script entry kinds; bit 0 doubles as the data/command flag for CMD/DATA.
  typedef enum logic [1:0] {
    KIND_CMD   = 2'd0,
    KIND_DATA  = 2'd1,
    KIND_DELAY = 2'd2,
    KIND_END   = 2'd3
  } entry_kind_e;

  typedef struct packed {
    entry_kind_e kind;
    logic [7:0]  val;
  } rom_entry_t;

  // ILI9488 opcodes
  localparam logic [7:0] OP_SWRESET  = 8'h01;
  localparam logic [7:0] OP_SLPOUT   = 8'h11;
  localparam logic [7:0] OP_COLMOD   = 8'h3A;
  localparam logic [7:0] OP_MADCTL   = 8'h36;
  localparam logic [7:0] OP_DISPON   = 8'h29;
  localparam logic [7:0] OP_CASET    = 8'h2A;
  localparam logic [7:0] OP_PASET    = 8'h2B;
  localparam logic [7:0] OP_RAMWR    = 8'h2C;
  localparam logic [7:0] OP_PGAMCTRL = 8'hE0;
  localparam logic [7:0] OP_NGAMCTRL = 8'hE1;

  // 18-bit pixels: three bytes per pixel on the 8-bit bus
  localparam logic [7:0] PIXFMT_18BPP = 8'h66;
  // Row/column exchange off, BGR order, mirrored X
  localparam logic [7:0] MADCTL_VAL   = 8'h48;

  // Script index width. Indices at or beyond ROM_DEPTH read back as END.
  localparam int ROM_IDX_W = 6;
`ifdef LCD_INIT_GAMMA_EN
  localparam int ROM_DEPTH = 41;
`else
  localparam int ROM_DEPTH = 9;
`endif

  typedef enum logic [2:0] {
    S_RST_ASSERT,
    S_RST_WAIT,
    S_FETCH,
    S_STROBE,
    S_GAP,
    S_DELAY,
    S_DONE
  } seq_state_e;

  function automatic rom_entry_t mk_entry(input entry_kind_e kind, input logic [7:0] val);
    rom_entry_t e;
    e.kind = kind;
    e.val  = val;
    return e;
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// ILI9488 power-up script, combinational index -> {kind, byte}.
// LCD_INIT_GAMMA_EN adds the positive/negative gamma tables before DISPON.
// The terminating END is not stored: every index past the table reads END.
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [ROM_IDX_W-1:0] idx_i,
  output rom_entry_t           entry_o
);

`ifdef LCD_INIT_GAMMA_EN
  // Gamma tables, first byte in the most significant position
  localparam logic [119:0] GAMMA_POS = {8'h00, 8'h03, 8'h09, 8'h08, 8'h16, 8'h0A, 8'h3F, 8'h78,
                                        8'h4C, 8'h09, 8'h0A, 8'h08, 8'h16, 8'h1A, 8'h0F};
  localparam logic [119:0] GAMMA_NEG = {8'h00, 8'h16, 8'h19, 8'h03, 8'h0F, 8'h05, 8'h32, 8'h45,
                                        8'h46, 8'h04, 8'h0E, 8'h0D, 8'h35, 8'h37, 8'h0F};

  function automatic logic [7:0] gamma_byte(input logic [119:0] tbl, input logic [ROM_IDX_W-1:0] k);
    return tbl[8*(14 - int'(k)) +: 8];
  endfunction
`endif

  // Decode the script index; unlisted indices fall through to END.
  always_comb begin
    entry_o = mk_entry(KIND_END, 8'h00);
    case (idx_i)
      6'd0: entry_o = mk_entry(KIND_CMD,   OP_SWRESET);
      6'd1: entry_o = mk_entry(KIND_DELAY, 8'd5);
      6'd2: entry_o = mk_entry(KIND_CMD,   OP_SLPOUT);
      6'd3: entry_o = mk_entry(KIND_DELAY, 8'd120);
      6'd4: entry_o = mk_entry(KIND_CMD,   OP_COLMOD);
      6'd5: entry_o = mk_entry(KIND_DATA,  PIXFMT_18BPP);
      6'd6: entry_o = mk_entry(KIND_CMD,   OP_MADCTL);
      6'd7: entry_o = mk_entry(KIND_DATA,  MADCTL_VAL);
`ifdef LCD_INIT_GAMMA_EN
      6'd8:  entry_o = mk_entry(KIND_CMD, OP_PGAMCTRL);
      6'd24: entry_o = mk_entry(KIND_CMD, OP_NGAMCTRL);
      6'd40: entry_o = mk_entry(KIND_CMD, OP_DISPON);
      default: begin
        if (idx_i >= 6'd9 && idx_i <= 6'd23) begin
          entry_o = mk_entry(KIND_DATA, gamma_byte(GAMMA_POS, idx_i - 6'd9));
        end else if (idx_i >= 6'd25 && idx_i <= 6'd39) begin
          entry_o = mk_entry(KIND_DATA, gamma_byte(GAMMA_NEG, idx_i - 6'd25));
        end
      end
`else
      6'd8:    entry_o = mk_entry(KIND_CMD, OP_DISPON);
      default: entry_o = mk_entry(KIND_END, 8'h00);
`endif
    endcase
  end

endmodule

// File: rtl/lcd_init_seq.sv
// ILI9488 power-up sequencer: pulses the panel hardware reset, waits for the
// panel to wake, then plays the script from lcd_init_rom onto the 8-bit bus
// (3 cycles per byte: FETCH, STROBE, GAP) and raises a sticky init_done.
// Build option LCD_INIT_GAMMA_EN (handled in lcd_init_rom) adds gamma setup.
module lcd_init_seq
  import lcd_pkg::*;
#(
  parameter int unsigned T_RST_LOW  = 500,
  parameter int unsigned T_RST_WAIT = 6000000,
  parameter int unsigned DELAY_UNIT = 50000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  output logic       lcd_rst_n,
  output logic [7:0] data_out,
  output logic       data_command,
  output logic       send_data,
  output logic       disp_cs,
  output logic       init_done
);

  localparam longint unsigned CNT_LIMIT = 64'd1 << CNT_W;

  // Reject configurations the counter compares cannot handle.
  generate
    if (T_RST_LOW == 0 || T_RST_WAIT == 0) begin : g_bad_timing
      $error("lcd_init_seq: T_RST_LOW and T_RST_WAIT must be nonzero");
    end
    if (64'(T_RST_LOW) >= CNT_LIMIT || 64'(T_RST_WAIT) >= CNT_LIMIT ||
        64'(255) * 64'(DELAY_UNIT) >= CNT_LIMIT) begin : g_bad_cnt_w
      $error("lcd_init_seq: CNT_W too narrow for the configured delays");
    end
    if (ROM_DEPTH >= (1 << ROM_IDX_W)) begin : g_bad_idx_w
      $error("lcd_init_seq: ROM_IDX_W cannot address the script");
    end
  endgenerate

  seq_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ROM_IDX_W-1:0] idx_q, idx_d;
  logic [7:0]           data_q, data_d;
  logic                 dc_q, dc_d;
  logic                 cs_q, cs_d;
  logic                 done_q, done_d;
  rom_entry_t           rom_entry;

  lcd_init_rom u_rom (
    .idx_i   (idx_q),
    .entry_o (rom_entry)
  );

  // State register and bus registers; rst_n returns everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= 8'h00;
      dc_q    <= 1'b0;
      cs_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      dc_q    <= dc_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; restart overrides whatever the script step decided.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    dc_d    = dc_q;
    cs_d    = cs_q;
    done_d  = done_q;

    case (state_q)
      S_RST_ASSERT: begin
        if (cnt_q == CNT_W'(T_RST_LOW - 1)) begin
          cnt_d   = '0;
          state_d = S_RST_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RST_WAIT: begin
        if (cnt_q == CNT_W'(T_RST_WAIT - 1)) begin
          cnt_d   = '0;
          cs_d    = 1'b0;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FETCH: begin
        case (rom_entry.kind)
          KIND_CMD, KIND_DATA: begin
            data_d  = rom_entry.val;
            dc_d    = (rom_entry.kind == KIND_DATA);
            state_d = S_STROBE;
          end
          KIND_DELAY: begin
            if (rom_entry.val == 8'd0) begin
              idx_d = idx_q + ROM_IDX_W'(1);
            end else begin
              cnt_d   = CNT_W'(rom_entry.val) * CNT_W'(DELAY_UNIT);
              state_d = S_DELAY;
            end
          end
          KIND_END: begin
            cs_d    = 1'b1;
            dc_d    = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
          default: state_d = S_DONE;
        endcase
      end
      S_STROBE: state_d = S_GAP;
      S_GAP: begin
        idx_d   = idx_q + ROM_IDX_W'(1);
        state_d = S_FETCH;
      end
      S_DELAY: begin
        // The delay entry's FETCH cycle is the first of its byte*DELAY_UNIT
        // cycles, so this state leaves one count early (at least one cycle).
        if (cnt_q <= CNT_W'(2)) begin
          cnt_d   = '0;
          idx_d   = idx_q + ROM_IDX_W'(1);
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_RST_ASSERT;
    endcase

    if (restart) begin
      state_d = S_RST_ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      cs_d    = 1'b1;
      done_d  = 1'b0;
    end
  end

  assign lcd_rst_n    = (state_q != S_RST_ASSERT);
  assign send_data    = (state_q == S_STROBE);
  assign data_out     = data_q;
  assign data_command = dc_q;
  assign disp_cs      = cs_q;
  assign init_done    = done_q;

endmodule

// File: tb/tb_lcd_init_seq.sv
`timescale 1ns/1ps
module tb_lcd_init_seq;

  localparam int T_LOW  = 4;
  localparam int T_WAIT = 6;
  localparam int DU     = 2;
`ifdef LCD_INIT_GAMMA_EN
  localparam int NEXP = 39;
`else
  localparam int NEXP = 7;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       restart = 1'b0;
  logic       lcd_rst_n;
  logic [7:0] data_out;
  logic       data_command;
  logic       send_data;
  logic       disp_cs;
  logic       init_done;

  int n_cmp = 0;
  int n_bad = 0;

  // Captured run: strobes as {dc, byte} with cycle index relative to the
  // posedge that left reset / took restart.
  int         cap_n;
  logic [8:0] cap_val [64];
  int         cap_cyc [64];
  int         cap_done;
  int         cap_low;
  int         cap_high;
  int         cap_cs_bad;

  logic [7:0] pos_g [15] = '{8'h00, 8'h03, 8'h09, 8'h08, 8'h16, 8'h0A, 8'h3F, 8'h78,
                             8'h4C, 8'h09, 8'h0A, 8'h08, 8'h16, 8'h1A, 8'h0F};
  logic [7:0] neg_g [15] = '{8'h00, 8'h16, 8'h19, 8'h03, 8'h0F, 8'h05, 8'h32, 8'h45,
                             8'h46, 8'h04, 8'h0E, 8'h0D, 8'h35, 8'h37, 8'h0F};

  always #5 clk = ~clk;

  lcd_init_seq #(
    .T_RST_LOW  (T_LOW),
    .T_RST_WAIT (T_WAIT),
    .DELAY_UNIT (DU),
    .CNT_W      (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .restart      (restart),
    .lcd_rst_n    (lcd_rst_n),
    .data_out     (data_out),
    .data_command (data_command),
    .send_data    (send_data),
    .disp_cs      (disp_cs),
    .init_done    (init_done)
  );

  // Expected {dc, byte} of strobe i (0-based).
  function automatic logic [8:0] exp_strobe(input int i);
    logic [8:0] r;
    r = {1'b0, 8'h29};
    if (i == 0)      r = {1'b0, 8'h01};
    else if (i == 1) r = {1'b0, 8'h11};
    else if (i == 2) r = {1'b0, 8'h3A};
    else if (i == 3) r = {1'b1, 8'h66};
    else if (i == 4) r = {1'b0, 8'h36};
    else if (i == 5) r = {1'b1, 8'h48};
`ifdef LCD_INIT_GAMMA_EN
    else if (i == 6)  r = {1'b0, 8'hE0};
    else if (i <= 21) r = {1'b1, pos_g[i-7]};
    else if (i == 22) r = {1'b0, 8'hE1};
    else if (i <= 37) r = {1'b1, neg_g[i-23]};
`endif
    return r;
  endfunction

  // Expected strobe cycle: 4 low + 6 wait, FETCH at 10, STROBE 11.
  // 0x11 at 11 + 5*2 + 3 = 24; 0x3A at 24 + 120*2 + 3 = 267; then every 3.
  function automatic int exp_cyc(input int i);
    if (i == 0) return 11;
    if (i == 1) return 24;
    return 267 + 3 * (i - 2);
  endfunction

  task automatic run_capture(input int k0, input int limit);
    bit seen_hi;
    bit seen_cs0;
    seen_hi = 0; seen_cs0 = 0;
    cap_n = 0; cap_done = -1; cap_low = 0; cap_high = 0; cap_cs_bad = 0;
    for (int k = k0; k <= limit; k++) begin
      @(negedge clk);
      if (!seen_hi && !lcd_rst_n) cap_low++;
      if (lcd_rst_n) seen_hi = 1;
      if (seen_hi && !seen_cs0 && disp_cs) cap_high++;
      if (!disp_cs) seen_cs0 = 1;
      if (send_data && cap_n < 64) begin
        cap_val[cap_n] = {data_command, data_out};
        cap_cyc[cap_n] = k;
        cap_n++;
      end
      if (init_done) begin
        cap_done = k;
        break;
      end
      if (cap_n > 0 && disp_cs) cap_cs_bad++;
    end
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    #1 restart = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (lcd_rst_n !== 1'b0) begin n_bad++; $display("FAIL rst_lcd_rst_n: got %b want 0", lcd_rst_n); end
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL rst_data_out: got %02h want 00", data_out); end
    n_cmp++; if (data_command !== 1'b0) begin n_bad++; $display("FAIL rst_data_command: got %b want 0", data_command); end
    n_cmp++; if (send_data !== 1'b0) begin n_bad++; $display("FAIL rst_send_data: got %b want 0", send_data); end
    n_cmp++; if (disp_cs !== 1'b1) begin n_bad++; $display("FAIL rst_disp_cs: got %b want 1", disp_cs); end
    n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL rst_init_done: got %b want 0", init_done); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_capture(0, 3000);
    $display("reset release: lcd_rst_n low %0d cycles, high %0d cycles before cs", cap_low, cap_high);
    n_cmp++; if (cap_low !== T_LOW) begin n_bad++; $display("FAIL rst_low_cycles: got %0d want %0d", cap_low, T_LOW); end
    n_cmp++; if (cap_high !== T_WAIT) begin n_bad++; $display("FAIL rst_wait_cycles: got %0d want %0d", cap_high, T_WAIT); end
  endtask

  task automatic test_script_run();
    n_cmp++; if (cap_n !== NEXP) begin n_bad++; $display("FAIL strobe_count: got %0d want %0d", cap_n, NEXP); end
    for (int i = 0; i < cap_n && i < NEXP; i++) begin
      $display("strobe %0d: dc=%0d data=%02h cycle=%0d", i, cap_val[i][8], cap_val[i][7:0], cap_cyc[i]);
      n_cmp++;
      if (cap_val[i] !== exp_strobe(i)) begin
        n_bad++; $display("FAIL strobe_val[%0d]: got %03h want %03h", i, cap_val[i], exp_strobe(i));
      end
      n_cmp++;
      if (cap_cyc[i] !== exp_cyc(i)) begin
        n_bad++; $display("FAIL strobe_cycle[%0d]: got %0d want %0d", i, cap_cyc[i], exp_cyc(i));
      end
    end
  endtask

  task automatic test_delay();
    int gap;
    gap = (cap_n >= 2) ? (cap_cyc[1] - cap_cyc[0]) : -1;
    $display("delay: 0x01 -> 0x11 strobe spacing %0d cycles", gap);
    n_cmp++; if (gap !== 5 * DU + 3) begin n_bad++; $display("FAIL delay_gap: got %0d want %0d", gap, 5 * DU + 3); end
    n_cmp++; if (cap_cs_bad !== 0) begin n_bad++; $display("FAIL cs_during_script: got %0d high samples want 0", cap_cs_bad); end
  endtask

  task automatic test_completion();
    int bad;
    bad = 0;
    $display("completion: init_done at cycle %0d", cap_done);
    n_cmp++;
    if (cap_done !== exp_cyc(NEXP - 1) + 3) begin
      n_bad++; $display("FAIL done_cycle: got %0d want %0d", cap_done, exp_cyc(NEXP - 1) + 3);
    end
    n_cmp++; if (disp_cs !== 1'b1) begin n_bad++; $display("FAIL done_disp_cs: got %b want 1", disp_cs); end
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (init_done !== 1'b1 || disp_cs !== 1'b1 || send_data !== 1'b0 || data_command !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL done_stable: got %0d bad samples want 0", bad); end
  endtask

  task automatic test_restart();
    int seen;
    logic [7:0] second;
    pulse_restart();
    @(negedge clk);
    n_cmp++; if (init_done !== 1'b0 || lcd_rst_n !== 1'b0 || disp_cs !== 1'b1) begin
      n_bad++; $display("FAIL restart_from_done: got done=%b rst=%b cs=%b want 0 0 1", init_done, lcd_rst_n, disp_cs);
    end
    seen = 0; second = 8'h00;
    for (int k = 0; k < 1000 && seen < 2; k++) begin
      @(negedge clk);
      if (send_data) begin seen++; second = data_out; end
    end
    repeat (5) @(negedge clk);
    n_cmp++; if (second !== 8'h11) begin n_bad++; $display("FAIL restart_pre_byte: got %02h want 11", second); end
    n_cmp++; if (disp_cs !== 1'b0 || lcd_rst_n !== 1'b1) begin
      n_bad++; $display("FAIL restart_pre_state: got cs=%b rst=%b want 0 1", disp_cs, lcd_rst_n);
    end
    pulse_restart();
    @(negedge clk);
    $display("restart in delay: done=%b lcd_rst_n=%b cs=%b send=%b", init_done, lcd_rst_n, disp_cs, send_data);
    n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL restart_done: got %b want 0", init_done); end
    n_cmp++; if (lcd_rst_n !== 1'b0) begin n_bad++; $display("FAIL restart_lcd_rst_n: got %b want 0", lcd_rst_n); end
    n_cmp++; if (disp_cs !== 1'b1) begin n_bad++; $display("FAIL restart_disp_cs: got %b want 1", disp_cs); end
    n_cmp++; if (send_data !== 1'b0) begin n_bad++; $display("FAIL restart_send: got %b want 0", send_data); end
    run_capture(1, 3000);
    n_cmp++; if (cap_n !== NEXP) begin n_bad++; $display("FAIL replay_count: got %0d want %0d", cap_n, NEXP); end
    n_cmp++; if (cap_n < 1 || cap_val[0] !== 9'h001 || cap_cyc[0] !== 11) begin
      n_bad++; $display("FAIL replay_first: got n=%0d val=%03h cyc=%0d want 001 at 11", cap_n, cap_val[0], cap_cyc[0]);
    end
    n_cmp++; if (cap_done !== exp_cyc(NEXP - 1) + 3) begin
      n_bad++; $display("FAIL replay_done: got %0d want %0d", cap_done, exp_cyc(NEXP - 1) + 3);
    end
  endtask

  task automatic test_restart_at_done();
    int dcyc;
    dcyc = exp_cyc(NEXP - 1) + 3;
    pulse_restart();
    for (int k = 0; k < dcyc; k++) @(negedge clk);
    n_cmp++; if (init_done !== 1'b0 || disp_cs !== 1'b0) begin
      n_bad++; $display("FAIL pre_done_state: got done=%b cs=%b want 0 0", init_done, disp_cs);
    end
    restart = 1'b1;
    @(posedge clk);
    #1 restart = 1'b0;
    @(negedge clk);
    $display("restart at done entry: done=%b lcd_rst_n=%b cs=%b", init_done, lcd_rst_n, disp_cs);
    n_cmp++; if (init_done !== 1'b0 || lcd_rst_n !== 1'b0 || disp_cs !== 1'b1) begin
      n_bad++; $display("FAIL restart_wins: got done=%b rst=%b cs=%b want 0 0 1", init_done, lcd_rst_n, disp_cs);
    end
  endtask

  task automatic test_async_reset();
    int seen;
    int target;
`ifdef LCD_INIT_GAMMA_EN
    target = 12;
`else
    target = 3;
`endif
    seen = 0;
    for (int k = 0; k < 3000 && seen < target; k++) begin
      @(negedge clk);
      if (send_data) seen++;
    end
    n_cmp++; if (seen !== target) begin n_bad++; $display("FAIL async_pre_strobes: got %0d want %0d", seen, target); end
    #1 rst_n = 1'b0;
    #1;
    $display("async reset mid-script: rst=%b data=%02h dc=%b send=%b cs=%b done=%b",
             lcd_rst_n, data_out, data_command, send_data, disp_cs, init_done);
    n_cmp++; if (lcd_rst_n !== 1'b0) begin n_bad++; $display("FAIL async_lcd_rst_n: got %b want 0", lcd_rst_n); end
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL async_data_out: got %02h want 00", data_out); end
    n_cmp++; if (data_command !== 1'b0) begin n_bad++; $display("FAIL async_dc: got %b want 0", data_command); end
    n_cmp++; if (send_data !== 1'b0) begin n_bad++; $display("FAIL async_send: got %b want 0", send_data); end
    n_cmp++; if (disp_cs !== 1'b1) begin n_bad++; $display("FAIL async_disp_cs: got %b want 1", disp_cs); end
    n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL async_done: got %b want 0", init_done); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run_capture(0, 3000);
    n_cmp++; if (cap_n < 1 || cap_val[0] !== 9'h001 || cap_cyc[0] !== 11) begin
      n_bad++; $display("FAIL post_reset_first: got n=%0d val=%03h cyc=%0d want 001 at 11", cap_n, cap_val[0], cap_cyc[0]);
    end
    n_cmp++; if (cap_n !== NEXP) begin n_bad++; $display("FAIL post_reset_count: got %0d want %0d", cap_n, NEXP); end
  endtask

  initial begin
    test_reset();
    test_script_run();
    test_delay();
    test_completion();
    test_restart();
    test_restart_at_done();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
